// File: rtl/subneg_prog_loader.sv
// Boot-time loader: streams program bytes into the external SRAM through the address latch, then starts the core.
// Optional read-back check of every written byte is compiled in with `define LOADER_VERIFY_EN.
module subneg_prog_loader #(
    parameter logic [7:0] BASE_ADDR = 8'h00,
    parameter int         WE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_go,
    input  logic [7:0] load_len,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] bus_out,
    output logic [7:0] bus_oe,
    input  logic [7:0] bus_in,
    output logic       latch_le,
    output logic       mem_oe_n,
    output logic       mem_we_n,
    output logic       busy,
    output logic       cpu_start,
    output logic       verify_err
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_WAIT,
        S_ADDR,
        S_LATCH,
        S_DATA,
        S_WE,
        S_WEND,
        S_DONE
`ifdef LOADER_VERIFY_EN
        ,
        S_VADDR,
        S_VLATCH,
        S_VOE,
        S_VSAMP,
        S_VEND
`endif
    } state_t;

    localparam logic [1:0] WE_LAST = 2'(WE_CYCLES - 1);

    state_t     state, state_nxt;
    logic [7:0] addr, addr_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic [7:0] byte_q, byte_nxt;
    logic [1:0] we_cnt, we_cnt_nxt;

    logic       in_ready_nxt;
    logic [7:0] bus_out_nxt;
    logic [7:0] bus_oe_nxt;
    logic       latch_le_nxt;
    logic       mem_oe_n_nxt;
    logic       mem_we_n_nxt;
    logic       busy_nxt;
    logic       cpu_start_nxt;

`ifdef LOADER_VERIFY_EN
    logic verr_q, verr_nxt;
    assign verify_err = verr_q;
`else
    logic unused_bus_in;
    assign unused_bus_in = ^bus_in;
    assign verify_err    = 1'b0;
`endif

    // Next-state and datapath updates
    always_comb begin
        state_nxt  = state;
        addr_nxt   = addr;
        cnt_nxt    = cnt;
        byte_nxt   = byte_q;
        we_cnt_nxt = we_cnt;
`ifdef LOADER_VERIFY_EN
        verr_nxt   = verr_q;
`endif
        case (state)
            S_IDLE: begin
                if (load_go) begin
`ifdef LOADER_VERIFY_EN
                    verr_nxt = 1'b0;
`endif
                    if (load_len != 8'd0) begin
                        addr_nxt  = BASE_ADDR;
                        cnt_nxt   = load_len;
                        state_nxt = S_WAIT;
                    end else begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_WAIT: begin
                if (in_valid) begin
                    byte_nxt  = in_data;
                    state_nxt = S_ADDR;
                end
            end
            S_ADDR:  state_nxt = S_LATCH;
            S_LATCH: state_nxt = S_DATA;
            S_DATA: begin
                we_cnt_nxt = 2'd0;
                state_nxt  = S_WE;
            end
            S_WE: begin
                if (we_cnt == WE_LAST) begin
                    state_nxt = S_WEND;
                end else begin
                    we_cnt_nxt = we_cnt + 2'd1;
                end
            end
            S_WEND: begin
                cnt_nxt = cnt - 8'd1;
`ifdef LOADER_VERIFY_EN
                // Address advances only after read-back so VADDR can re-present it
                state_nxt = S_VADDR;
`else
                addr_nxt  = addr + 8'd1;
                state_nxt = (cnt != 8'd1) ? S_WAIT : S_DONE;
`endif
            end
            S_DONE: state_nxt = S_IDLE;
`ifdef LOADER_VERIFY_EN
            S_VADDR:  state_nxt = S_VLATCH;
            S_VLATCH: state_nxt = S_VOE;
            S_VOE:    state_nxt = S_VSAMP;
            S_VSAMP: begin
                if (bus_in != byte_q) begin
                    verr_nxt = 1'b1;
                end
                state_nxt = S_VEND;
            end
            S_VEND: begin
                addr_nxt  = addr + 8'd1;
                state_nxt = (cnt != 8'd0) ? S_WAIT : S_DONE;
            end
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming state and registered, so they are glitch-free
    always_comb begin
        in_ready_nxt  = (state_nxt == S_WAIT);
        busy_nxt      = (state_nxt != S_IDLE) && (state_nxt != S_DONE);
        cpu_start_nxt = (state_nxt == S_DONE);
        mem_we_n_nxt  = (state_nxt != S_WE);
        mem_oe_n_nxt  = 1'b1;
        bus_oe_nxt    = busy_nxt ? 8'hFF : 8'h00;
        latch_le_nxt  = latch_le;
        bus_out_nxt   = bus_out;
        case (state_nxt)
            S_IDLE, S_DONE: latch_le_nxt = 1'b1;
            S_ADDR: begin
                latch_le_nxt = 1'b1;
                bus_out_nxt  = addr_nxt;
            end
            S_LATCH: begin
                latch_le_nxt = 1'b0;
                bus_out_nxt  = addr_nxt;
            end
            S_DATA: bus_out_nxt = byte_nxt;
`ifdef LOADER_VERIFY_EN
            S_VADDR: begin
                latch_le_nxt = 1'b1;
                bus_out_nxt  = addr_nxt;
            end
            S_VLATCH: latch_le_nxt = 1'b0;
            S_VOE, S_VSAMP: begin
                bus_oe_nxt   = 8'h00;
                mem_oe_n_nxt = 1'b0;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            addr      <= BASE_ADDR;
            cnt       <= 8'd0;
            we_cnt    <= 2'd0;
            in_ready  <= 1'b0;
            bus_out   <= 8'h00;
            bus_oe    <= 8'h00;
            latch_le  <= 1'b1;
            mem_oe_n  <= 1'b1;
            mem_we_n  <= 1'b1;
            busy      <= 1'b0;
            cpu_start <= 1'b0;
`ifdef LOADER_VERIFY_EN
            verr_q    <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            addr      <= addr_nxt;
            cnt       <= cnt_nxt;
            we_cnt    <= we_cnt_nxt;
            in_ready  <= in_ready_nxt;
            bus_out   <= bus_out_nxt;
            bus_oe    <= bus_oe_nxt;
            latch_le  <= latch_le_nxt;
            mem_oe_n  <= mem_oe_n_nxt;
            mem_we_n  <= mem_we_n_nxt;
            busy      <= busy_nxt;
            cpu_start <= cpu_start_nxt;
`ifdef LOADER_VERIFY_EN
            verr_q    <= verr_nxt;
`endif
        end
    end

    // Captured program byte needs no reset; it is always written before use
    always_ff @(posedge clk) begin
        byte_q <= byte_nxt;
    end

endmodule

// File: tb/tb_subneg_prog_loader.sv
// Directed bench for subneg_prog_loader: two instances (base 00 / WE 1 and base FE / WE 3) each with an SRAM+latch model.
module tb_subneg_prog_loader;

    logic       clk;
    logic       reset;
    logic       load_go [2];
    logic [7:0] load_len;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready [2];
    logic [7:0] bus_out [2];
    logic [7:0] bus_oe [2];
    logic       latch_le [2];
    logic       mem_oe_n [2];
    logic       mem_we_n [2];
    logic       busy [2];
    logic       cpu_start [2];
    logic       verify_err [2];
    logic [7:0] bus_in0;
    logic       corrupt;

    logic [7:0] mem [2][256];
    logic [7:0] lat [2];
    logic       prev_le [2];
    logic       prev_we [2];
    logic [7:0] prev_bus [2];
    int         we_low [2];

    int checks = 0;
    int errors = 0;

    subneg_prog_loader #(.BASE_ADDR(8'h00), .WE_CYCLES(1)) dut (
        .clk(clk), .reset(reset), .load_go(load_go[0]), .load_len(load_len),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready[0]),
        .bus_out(bus_out[0]), .bus_oe(bus_oe[0]), .bus_in(bus_in0),
        .latch_le(latch_le[0]), .mem_oe_n(mem_oe_n[0]), .mem_we_n(mem_we_n[0]),
        .busy(busy[0]), .cpu_start(cpu_start[0]), .verify_err(verify_err[0])
    );

    subneg_prog_loader #(.BASE_ADDR(8'hFE), .WE_CYCLES(3)) dut_w (
        .clk(clk), .reset(reset), .load_go(load_go[1]), .load_len(load_len),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready[1]),
        .bus_out(bus_out[1]), .bus_oe(bus_oe[1]), .bus_in(8'h00),
        .latch_le(latch_le[1]), .mem_oe_n(mem_oe_n[1]), .mem_we_n(mem_we_n[1]),
        .busy(busy[1]), .cpu_start(cpu_start[1]), .verify_err(verify_err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM read-back for the base-00 instance; address 1 can be corrupted on read
    assign bus_in0 = mem_oe_n[0] ? 8'h00
                   : (mem[0][lat[0]] ^ ((corrupt && lat[0] == 8'h01) ? 8'hFF : 8'h00));

    // Latch/SRAM model plus bus-protocol monitor, evaluated away from the active edge
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!reset) begin
                if (mem_we_n[k] === 1'b0) begin
                    we_low[k]++;
                    checks++;
                    assert (mem_oe_n[k] === 1'b1) else begin
                        errors++;
                        $error("FAIL oe_we_overlap[%0d]: mem_oe_n=%b required 1", k, mem_oe_n[k]);
                    end
                    checks++;
                    if (prev_we[k] === 1'b0) begin
                        assert (bus_out[k] === prev_bus[k]) else begin
                            errors++;
                            $error("FAIL bus_stable_we[%0d]: bus_out=%h required %h", k, bus_out[k], prev_bus[k]);
                        end
                    end else begin
                        assert (!(latch_le[k] === 1'b1 && prev_le[k] === 1'b0)) else begin
                            errors++;
                            $error("FAIL le_rise_with_we[%0d]: latch_le=%b required 0", k, latch_le[k]);
                        end
                    end
                end
                if (busy[k] === 1'b1) begin
                    checks++;
                    assert ((mem_oe_n[k] === 1'b0) === (bus_oe[k] === 8'h00)) else begin
                        errors++;
                        $error("FAIL oe_tristate[%0d]: bus_oe=%h mem_oe_n=%b", k, bus_oe[k], mem_oe_n[k]);
                    end
                end
            end
            if (prev_le[k] === 1'b1 && latch_le[k] === 1'b0) lat[k] = bus_out[k];
            if (prev_we[k] === 1'b0 && mem_we_n[k] === 1'b1) mem[k][lat[k]] = bus_out[k];
            prev_le[k]  = latch_le[k];
            prev_we[k]  = mem_we_n[k];
            prev_bus[k] = bus_out[k];
        end
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic start_load(input int k, input logic [7:0] len);
        @(negedge clk);
        load_len   = len;
        load_go[k] = 1'b1;
        @(negedge clk);
        load_go[k] = 1'b0;
    endtask

    // Returns on the falling edge right after the accepting rising edge
    task automatic send_byte(input int k, input logic [7:0] b, input string tag);
        int t;
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        while (in_ready[k] !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk1({tag, "_accept_timeout"}, (t < 100), 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_ready(input int k, input string tag);
        int t;
        t = 0;
        while (in_ready[k] !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk1({tag, "_ready_timeout"}, (t < 50), 1'b1);
    endtask

    task automatic wait_done(input int k, input string tag);
        int t;
        t = 0;
        while (cpu_start[k] !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk1({tag, "_done_timeout"}, (t < 200), 1'b1);
        chk1({tag, "_busy_at_done"}, busy[k], 1'b0);
        chk8({tag, "_oe_at_done"}, bus_oe[k], 8'h00);
        @(negedge clk);
        chk1({tag, "_start_single"}, cpu_start[k], 1'b0);
        chk1({tag, "_busy_after"}, busy[k], 1'b0);
    endtask

    // Hold in_valid low in WAIT and confirm nothing on the bus moves
    task automatic stall(input int k, input int n, input bit poke_go, input string tag);
        logic       le0;
        logic [7:0] bo0;
        le0 = latch_le[k];
        bo0 = bus_out[k];
        if (poke_go) begin
            load_len   = 8'd1;
            load_go[k] = 1'b1;
        end
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            load_go[k] = 1'b0;
            chk1({tag, "_ready"}, in_ready[k], 1'b1);
            chk1({tag, "_we_n"}, mem_we_n[k], 1'b1);
            chk1({tag, "_le"}, latch_le[k], le0);
            chk8({tag, "_bus"}, bus_out[k], bo0);
        end
    endtask

    initial begin
        int lat_cnt;
        int t;
        reset      = 1'b1;
        load_go[0] = 1'b0;
        load_go[1] = 1'b0;
        load_len   = 8'd0;
        in_data    = 8'h00;
        in_valid   = 1'b0;
        corrupt    = 1'b0;
        we_low[0]  = 0;
        we_low[1]  = 0;
        lat[0]     = 8'h00;
        lat[1]     = 8'h00;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 256; i++) mem[k][i] = 8'h00;
        repeat (3) @(negedge clk);

        // Reset state
        chk1("rst_in_ready", in_ready[0], 1'b0);
        chk8("rst_bus_out", bus_out[0], 8'h00);
        chk8("rst_bus_oe", bus_oe[0], 8'h00);
        chk1("rst_latch_le", latch_le[0], 1'b1);
        chk1("rst_mem_oe_n", mem_oe_n[0], 1'b1);
        chk1("rst_mem_we_n", mem_we_n[0], 1'b1);
        chk1("rst_busy", busy[0], 1'b0);
        chk1("rst_cpu_start", cpu_start[0], 1'b0);
        chk1("rst_verify_err", verify_err[0], 1'b0);
        reset = 1'b0;
        @(negedge clk);

        // Test 1: three bytes back-to-back at base 00
        we_low[0] = 0;
        start_load(0, 8'd3);
        chk1("t1_busy", busy[0], 1'b1);
        chk8("t1_bus_oe", bus_oe[0], 8'hFF);
        chk1("t1_in_ready", in_ready[0], 1'b1);
        send_byte(0, 8'h10, "t1_b0");
        lat_cnt = 0;
        while (mem_we_n[0] === 1'b1 && lat_cnt < 20) begin
            @(negedge clk);
            lat_cnt++;
        end
        chki("t1_accept_to_we", lat_cnt, 3);
        send_byte(0, 8'h20, "t1_b1");
        send_byte(0, 8'h30, "t1_b2");
        wait_done(0, "t1");
        chk8("t1_mem0", mem[0][0], 8'h10);
        chk8("t1_mem1", mem[0][1], 8'h20);
        chk8("t1_mem2", mem[0][2], 8'h30);
        chki("t1_we_low_cycles", we_low[0], 3);

        // Test 2: zero-length load goes straight to DONE
        we_low[0] = 0;
        start_load(0, 8'd0);
        chk1("t2_cpu_start", cpu_start[0], 1'b1);
        chk1("t2_busy", busy[0], 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk1("t2_start_low", cpu_start[0], 1'b0);
            chk1("t2_busy_low", busy[0], 1'b0);
        end
        chki("t2_no_we", we_low[0], 0);

        // Test 3: base FE wraps to 00, three-cycle write pulse
        we_low[1] = 0;
        start_load(1, 8'd3);
        chk1("t3_busy", busy[1], 1'b1);
        send_byte(1, 8'hAA, "t3_b0");
        send_byte(1, 8'hBB, "t3_b1");
        send_byte(1, 8'hCC, "t3_b2");
        wait_done(1, "t3");
        chk8("t3_memFE", mem[1][8'hFE], 8'hAA);
        chk8("t3_memFF", mem[1][8'hFF], 8'hBB);
        chk8("t3_mem00", mem[1][8'h00], 8'hCC);
        chki("t3_we_low_cycles", we_low[1], 9);

        // Test 4: stalls between bytes; load_go while busy is ignored
        start_load(0, 8'd3);
        send_byte(0, 8'h5A, "t4_b0");
        wait_ready(0, "t4_w0");
        stall(0, 5, 1'b1, "t4_stall0");
        send_byte(0, 8'hA5, "t4_b1");
        wait_ready(0, "t4_w1");
        stall(0, 5, 1'b0, "t4_stall1");
        send_byte(0, 8'h3C, "t4_b2");
        wait_done(0, "t4");
        chk8("t4_mem0", mem[0][0], 8'h5A);
        chk8("t4_mem1", mem[0][1], 8'hA5);
        chk8("t4_mem2", mem[0][2], 8'h3C);

        // Test 5: reset while the second of four bytes is being written
        start_load(0, 8'd4);
        send_byte(0, 8'h01, "t5_b0");
        send_byte(0, 8'h02, "t5_b1");
        t = 0;
        while (mem_we_n[0] === 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk1("t5_we_seen", (t < 20), 1'b1);
        reset = 1'b1;
        @(negedge clk);
        chk1("t5_we_n", mem_we_n[0], 1'b1);
        chk1("t5_busy", busy[0], 1'b0);
        chk8("t5_bus_oe", bus_oe[0], 8'h00);
        chk1("t5_in_ready", in_ready[0], 1'b0);
        reset = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'hEE;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk1("t5_idle_not_ready", in_ready[0], 1'b0);
        end
        in_valid = 1'b0;
        start_load(0, 8'd2);
        send_byte(0, 8'h77, "t5_n0");
        send_byte(0, 8'h88, "t5_n1");
        wait_done(0, "t5");
        chk8("t5_mem0", mem[0][0], 8'h77);
        chk8("t5_mem1", mem[0][1], 8'h88);

`ifdef LOADER_VERIFY_EN
        // Test 6: read-back of address 1 is corrupted
        corrupt = 1'b1;
        start_load(0, 8'd3);
        send_byte(0, 8'h11, "t6_b0");
        wait_ready(0, "t6_w0");
        chk1("t6_err_after_b0", verify_err[0], 1'b0);
        send_byte(0, 8'h22, "t6_b1");
        wait_ready(0, "t6_w1");
        chk1("t6_err_after_b1", verify_err[0], 1'b1);
        send_byte(0, 8'h33, "t6_b2");
        wait_done(0, "t6");
        chk1("t6_err_sticky", verify_err[0], 1'b1);
        chk8("t6_mem0", mem[0][0], 8'h11);
        chk8("t6_mem1", mem[0][1], 8'h22);
        chk8("t6_mem2", mem[0][2], 8'h33);
        corrupt = 1'b0;
        start_load(0, 8'd1);
        chk1("t6_err_cleared", verify_err[0], 1'b0);
        send_byte(0, 8'h44, "t6_n0");
        wait_done(0, "t6n");
        chk1("t6_err_clean", verify_err[0], 1'b0);
`else
        chk1("t6_verify_tied", verify_err[0], 1'b0);
`endif

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
